regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of write requesters sharing the register-file write port.
REQ-002 Parameter AW, 3, write address width; the address drives the 3-to-8 write decoder select inputs.
REQ-003 Parameter DW, 8, write data width.
REQ-004 Parameter MAXBURST, 4, maximum consecutive grant cycles in one locked burst.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of Clock.
REQ-006 Port list (name, direction, width, meaning):
 - Clock  in  1  sole clock.
 - Reset  in  1  synchronous active-high reset.
 - Req  in  NREQ  per-requester write request, level.
 - Lock  in  NREQ  per-requester burst request, sampled with Req.
 - AddrIn  in  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW].
 - DataIn  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
 - Grant  out  NREQ  one-hot or zero, registered acknowledge.
 - WrEn  out  1  registered write enable; drives the decoder EN input.
 - WrAddr  out  AW  registered write address; drives decoder W2..W0.
 - WrData  out  DW  registered write data to the register file.

Function
REQ-007 State machine states SHALL be IDLE (no grant), SINGLE (one-cycle grant), and BURST (locked grant).
REQ-008 Arbitration edge: when no grant is active, or the current grant ends, the block SHALL pick the first i with Req[i]=1, searching Ptr, Ptr+1, ... mod NREQ, and SHALL assert Grant[i] in the next cycle.
REQ-009 After a pick of i, Ptr SHALL become (i+1) mod NREQ.
REQ-010 Next state after a pick: BURST if Lock[i]=1 at the pick edge; otherwise SINGLE. If no Req is asserted, next state is IDLE.
REQ-011 Grant-cycle capture: at the edge ending a cycle with Grant[i]=1 and Req[i]=1, the block SHALL register WrAddr=AddrIn[i], WrData=DataIn[i], and WrEn=1.
REQ-012 If Req[i]=0 during a Grant[i] cycle, that cycle SHALL produce no write: WrEn=0 next cycle and WrAddr/WrData hold.
REQ-013 Latency: Req high in cycle N with no contention gives Grant in N+1 and WrEn in N+2; requesters SHALL hold Addr/Data/Req stable through the Grant cycle.
REQ-014 SINGLE: Grant SHALL last exactly one cycle, and Req[i] during that cycle SHALL NOT be considered at the following arbitration edge; the pick at that edge excludes i.
REQ-015 BURST: Grant[i] SHALL remain high while Req[i]=1 and Lock[i]=1 and the burst count is less than MAXBURST.
REQ-016 BURST counting: the count starts at 1 in the first grant cycle and increments on each grant cycle.
REQ-017 BURST exit: the burst SHALL end after the grant cycle in which Req[i]=0, Lock[i]=0, or the count reaches MAXBURST.
REQ-018 On burst exit, re-arbitration SHALL happen at that same edge with i excluded, giving no idle bubble when others request.
REQ-019 At most one Grant bit SHALL be high in any cycle, and WrEn SHALL be high for at most one write per cycle.
REQ-020 Back-to-back grants to different requesters SHALL sustain one write per cycle.
REQ-021 If the only requester is excluded at an edge, the next state is IDLE, and that requester is regranted at the following edge.

Reset
REQ-022 Reset SHALL set Grant=0, WrEn=0, WrAddr=0, WrData=0, Ptr=0, burst count=0, and state=IDLE on the next rising edge.
REQ-023 Reset mid-burst or mid-grant SHALL abort without a write: WrEn=0 in the cycle after the reset edge.
REQ-024 Reset SHALL take priority over all other inputs.

Structure
REQ-025 A shared constants file regfile_pkg SHALL hold the state encodings, NREQ/AW/DW/MAXBURST defaults, and the burst count width (clog2(MAXBURST)+1).
REQ-026 One sub-module rr_pick SHALL be used: a combinational round-robin picker with inputs request vector, Ptr, and exclude mask, and outputs a valid flag and a one-hot pick.

Verification
REQ-027 Single request: Req=0001, AddrIn[0]=5, DataIn[0]=0xA5 in cycle 1 -> Grant=0001 in cycle 2; WrEn=1, WrAddr=5, WrData=0xA5 in cycle 3.
REQ-028 Round robin: Req=1111 held, Lock=0 -> Grant sequence 0001, 0010, 0100, 1000, 0001, with a WrEn on every cycle from cycle 3.
REQ-029 Burst cap: Req[2]=Lock[2]=1 held, Req[0]=1 -> Grant=0100 for exactly 4 cycles, then Grant=0001, then Grant=0100 again.
REQ-030 Burst abort: Req[1] drops in the 2nd grant cycle of a burst -> that cycle produces no write and the burst ends.
REQ-031 Reset mid-burst: Reset pulsed in the 3rd burst cycle -> Grant=0, WrEn=0, WrAddr=0, and WrData=0 next cycle; with Req=1110 the first grant after release is 0010 (Ptr=0).
REQ-032 Checker: Grant is one-hot or zero every cycle, and each WrEn matches exactly one Grant cycle with Req high.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: default sizes,
// FSM state encodings and the burst counter width helper.
package regfile_pkg;

    localparam int RF_NREQ     = 4;
    localparam int RF_AW       = 3;
    localparam int RF_DW       = 8;
    localparam int RF_MAXBURST = 4;

    // Counter must be able to hold MAXBURST itself, hence the extra bit.
    function automatic int burst_cw(input int maxburst);
        return $clog2(maxburst) + 1;
    endfunction

    localparam int RF_CW = burst_cw(RF_MAXBURST);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SINGLE = 2'd1;
    localparam logic [1:0] ST_BURST  = 2'd2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i (mod N),
// ignoring excluded requesters; one-hot result plus a valid flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          vld_o,
    output logic [N-1:0]  pick_o
);

    logic [N-1:0]   masked;
    logic [N-1:0]   rot;
    logic [N-1:0]   first;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] back;

    assign masked = req_i & ~excl_i;

    // Rotate so ptr_i lands on bit 0, isolate the lowest set bit, rotate back.
    // Both halves are OR-ed because they carry the same bits where valid.
    assign dbl    = {masked, masked} >> ptr_i;
    assign rot    = dbl[N-1:0] | dbl[2*N-1:N];
    assign first  = rot & (-rot);
    assign back   = {first, first} << ptr_i;
    assign pick_o = back[2*N-1:N] | back[N-1:0];
    assign vld_o  = |masked;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the shared register-file write port with optional
// locked bursts; grant one cycle after request, write one cycle after grant.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ     = RF_NREQ,
    parameter int AW       = RF_AW,
    parameter int DW       = RF_DW,
    parameter int MAXBURST = RF_MAXBURST
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NREQ-1:0]    Req,
    input  logic [NREQ-1:0]    Lock,
    input  logic [NREQ*AW-1:0] AddrIn,
    input  logic [NREQ*DW-1:0] DataIn,
    output logic [NREQ-1:0]    Grant,
    output logic               WrEn,
    output logic [AW-1:0]      WrAddr,
    output logic [DW-1:0]      WrData
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = burst_cw(MAXBURST);

    logic [1:0]      state_q,   state_d;
    logic [NREQ-1:0] grant_q,   grant_d;
    logic [PW-1:0]   ptr_q,     ptr_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            wr_en_q,   wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   p_idx;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            burst_cont;

    // grant_q is zero in IDLE, so it doubles as the exclusion mask.
    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req_i  (Req),
        .ptr_i  (ptr_q),
        .excl_i (grant_q),
        .vld_o  (pick_vld),
        .pick_o (pick)
    );

    always_comb begin
        g_idx = '0;
        p_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) g_idx = PW'(i);
            if (pick[i])    p_idx = PW'(i);
        end
    end

    assign burst_cont = (state_q == ST_BURST) && Req[g_idx] && Lock[g_idx]
                        && (cnt_q < CW'(MAXBURST));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // A grant cycle only writes if the requester still holds Req.
        if (state_q != ST_IDLE && Req[g_idx]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AddrIn[g_idx*AW +: AW];
            wr_data_d = DataIn[g_idx*DW +: DW];
        end

        if (burst_cont) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pick_vld) begin
            grant_d = pick;
            ptr_d   = (p_idx == PW'(NREQ-1)) ? '0 : p_idx + PW'(1);
            if (Lock[p_idx]) begin
                state_d = ST_BURST;
                cnt_d   = CW'(1);
            end else begin
                state_d = ST_SINGLE;
                cnt_d   = '0;
            end
        end else begin
            grant_d = '0;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign Grant  = grant_q;
    assign WrEn   = wr_en_q;
    assign WrAddr = wr_addr_q;
    assign WrData = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios push expected grants and
// writes into queues; a negedge monitor pops and compares them.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;

    logic               Clock = 1'b0;
    logic               Reset;
    logic [NREQ-1:0]    Req;
    logic [NREQ-1:0]    Lock;
    logic [NREQ*AW-1:0] AddrIn;
    logic [NREQ*DW-1:0] DataIn;
    logic [NREQ-1:0]    Grant;
    logic               WrEn;
    logic [AW-1:0]      WrAddr;
    logic [DW-1:0]      WrData;

    int tests = 0;
    int fails = 0;

    logic [NREQ-1:0]  exp_gnt_q[$];
    logic [AW+DW-1:0] exp_wr_q[$];
    bit               mon_en = 1'b0;
    logic [NREQ-1:0]  prev_gr = '0;
    logic             prev_rst = 1'b1;

    regfile_wr_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .MAXBURST(4)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Req    (Req),
        .Lock   (Lock),
        .AddrIn (AddrIn),
        .DataIn (DataIn),
        .Grant  (Grant),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrData (WrData)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_gnt(input logic [NREQ-1:0] g, input int n);
        for (int k = 0; k < n; k++) exp_gnt_q.push_back(g);
    endtask

    task automatic push_wr(input int idx, input int n);
        for (int k = 0; k < n; k++)
            exp_wr_q.push_back({AddrIn[idx*AW +: AW], DataIn[idx*DW +: DW]});
    endtask

    // Monitor: one-hot grant, write-follows-grant model, ordered scoreboards.
    always @(negedge Clock) begin
        if (mon_en) begin
            check("grant_onehot0", {31'b0, $onehot0(Grant)}, 32'd1);
            check("wren_follows_grant", {31'b0, WrEn}, {31'b0, (|prev_gr) && !prev_rst});
            if (Grant != '0) begin
                if (exp_gnt_q.size() == 0) check("grant_unexpected", {28'b0, Grant}, 32'd0);
                else check("grant_seq", {28'b0, Grant}, {28'b0, exp_gnt_q.pop_front()});
            end
            if (WrEn) begin
                if (exp_wr_q.size() == 0) check("write_unexpected", {21'b0, WrAddr, WrData}, 32'd0);
                else check("write_addr_data", {21'b0, WrAddr, WrData}, {21'b0, exp_wr_q.pop_front()});
            end
        end
        prev_gr  <= Grant & Req;
        prev_rst <= Reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Req = '0; Lock = '0; AddrIn = '0; DataIn = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_grant",  {28'b0, Grant}, 32'd0);
        check("reset_wren",   {31'b0, WrEn}, 32'd0);
        check("reset_waddr",  {29'b0, WrAddr}, 32'd0);
        check("reset_wdata",  {24'b0, WrData}, 32'd0);
        mon_en = 1'b1;

        // Single request: grant next cycle, write the cycle after.
        Reset = 1'b0;
        AddrIn[0 +: AW] = 3'd5;
        DataIn[0 +: DW] = 8'hA5;
        Req = 4'b0001;
        push_gnt(4'b0001, 1); push_wr(0, 1);
        step();
        check("single_grant_lat", {28'b0, Grant}, 32'h1);
        step();
        check("single_wren_lat", {31'b0, WrEn}, 32'd1);
        check("single_waddr", {29'b0, WrAddr}, 32'd5);
        check("single_wdata", {24'b0, WrData}, 32'hA5);
        Req = '0;
        Reset = 1'b1;

        for (int i = 0; i < NREQ; i++) begin
            AddrIn[i*AW +: AW] = AW'(i);
            DataIn[i*DW +: DW] = DW'(8'h10 + i);
        end

        // Round robin from Ptr=0 after reset.
        step();
        Reset = 1'b0;
        Req = 4'b1111;
        push_gnt(4'b0001, 1); push_gnt(4'b0010, 1); push_gnt(4'b0100, 1);
        push_gnt(4'b1000, 1); push_gnt(4'b0001, 1);
        push_wr(0, 1); push_wr(1, 1); push_wr(2, 1); push_wr(3, 1); push_wr(0, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", {28'b0, Grant}, 32'(1 << (k % 4)));
            if (k >= 1) check("rr_wren", {31'b0, WrEn}, 32'd1);
            if (k == 4) Req = 4'b0001;
        end
        step();
        check("rr_last_wren", {31'b0, WrEn}, 32'd1);
        Req = '0;

        // Burst cap of 4 with requester 0 waiting, then burst again (Ptr=1).
        step();
        Req = 4'b0100; Lock = 4'b0100;
        push_gnt(4'b0100, 4); push_gnt(4'b0001, 1); push_gnt(4'b0100, 1);
        push_wr(2, 4); push_wr(0, 1); push_wr(2, 1);
        for (int k = 0; k < 6; k++) begin
            step();
            check("burst_cap_grant", {28'b0, Grant}, (k == 4) ? 32'h1 : 32'h4);
            if (k == 0) Req = 4'b0101;
            if (k == 5) begin Req = 4'b0100; Lock = '0; end
        end
        step();
        Req = '0;
        check("burst_end_idle", {28'b0, Grant}, 32'd0);

        // Burst abort: Req drops in the 2nd grant cycle (Ptr=3 -> picks 1).
        step();
        Req = 4'b0010; Lock = 4'b0010;
        push_gnt(4'b0010, 2); push_wr(1, 1);
        step();
        check("abort_grant1", {28'b0, Grant}, 32'h2);
        step();
        check("abort_grant2", {28'b0, Grant}, 32'h2);
        Req = '0;
        step();
        check("abort_grant_off", {28'b0, Grant}, 32'd0);
        check("abort_no_write", {31'b0, WrEn}, 32'd0);
        check("abort_addr_hold", {29'b0, WrAddr}, 32'd1);
        check("abort_data_hold", {24'b0, WrData}, 32'h11);
        Lock = '0;

        // Reset in the 3rd burst cycle, then Ptr=0 picks requester 1.
        step();
        Req = 4'b0100; Lock = 4'b0100;
        push_gnt(4'b0100, 3); push_wr(2, 2);
        step();
        step();
        step();
        check("rst_burst_grant3", {28'b0, Grant}, 32'h4);
        Reset = 1'b1;
        step();
        check("rst_mid_grant", {28'b0, Grant}, 32'd0);
        check("rst_mid_wren", {31'b0, WrEn}, 32'd0);
        check("rst_mid_waddr", {29'b0, WrAddr}, 32'd0);
        check("rst_mid_wdata", {24'b0, WrData}, 32'd0);
        Reset = 1'b0; Req = 4'b1110; Lock = '0;
        push_gnt(4'b0010, 1); push_wr(1, 1);
        step();
        check("post_rst_grant", {28'b0, Grant}, 32'h2);
        Req = 4'b0010;
        step();
        check("post_rst_wren", {31'b0, WrEn}, 32'd1);
        check("post_rst_waddr", {29'b0, WrAddr}, 32'd1);
        Req = '0;

        repeat (3) step();
        check("grant_queue_drained", exp_gnt_q.size(), 32'd0);
        check("write_queue_drained", exp_wr_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
